// File: rtl/sign_mag_seq_mult_pkg.sv
// rtl/sign_mag_seq_mult_pkg.sv - shared width default and controller states for sign_mag_seq_mult
package sign_mag_seq_mult_pkg;

   localparam int WIDTH_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sign_mag_seq_mult_dp.sv
// rtl/sign_mag_seq_mult_dp.sv - shift-and-add datapath: accumulator, operand shifters, iteration counter
module sign_mag_seq_mult_dp #(
   parameter int M  = 5,
   parameter int CW = $clog2(M + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           step,
   input  logic [M-1:0]   mag_a_in,
   input  logic [M-1:0]   mag_b_in,
   input  logic           sign_in,
   output logic [2*M-1:0] acc_next,
   output logic           last,
   output logic           sign
);

   logic [2*M-1:0] mcand;
   logic [2*M-1:0] acc;
   logic [M-1:0]   mplier;
   logic [CW-1:0]  count;

   // Multiplicand shifts left each step, so the add never needs an index.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign last     = (count == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
         sign   <= 1'b0;
      end else if (load) begin
         mcand  <= {{M{1'b0}}, mag_a_in};
         acc    <= '0;
         mplier <= mag_b_in;
         count  <= CW'(M);
         sign   <= sign_in;
      end else if (step) begin
         mcand  <= mcand << 1;
         acc    <= acc_next;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
      end
   end

endmodule

// File: rtl/sign_mag_seq_mult.sv
// rtl/sign_mag_seq_mult.sv - sequential sign-magnitude multiplier, result valid M cycles after start
module sign_mag_seq_mult
   import sign_mag_seq_mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int M = WIDTH - 1;

   state_t         state_q;
   state_t         state_d;
   logic           step;
   logic           last;
   logic           sign;
   logic [2*M-1:0] acc_next;

   sign_mag_seq_mult_dp #(.M(M)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .step     (step),
      .mag_a_in (a[M-1:0]),
      .mag_b_in (b[M-1:0]),
      .sign_in  (a[WIDTH-1] ^ b[WIDTH-1]),
      .acc_next (acc_next),
      .last     (last),
      .sign     (sign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A start in any state reloads; it wins over a pending iteration.
   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      if (start) begin
         state_d = BUSY;
      end else begin
         case (state_q)
            BUSY: begin
               step = 1'b1;
               if (last) state_d = DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Zero magnitude never carries a sign bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done    <= 1'b0;
         product <= '0;
      end else if (start) begin
         done    <= 1'b0;
         product <= '0;
      end else if (step && last) begin
         done    <= 1'b1;
         product <= {sign & (|acc_next), {(2*WIDTH-1-2*M){1'b0}}, acc_next};
      end
   end

endmodule

// File: tb/tb_sign_mag_seq_mult.sv
// tb/tb_sign_mag_seq_mult.sv - self-checking bench: vector table, corner sequences, random ops vs model
module tb_sign_mag_seq_mult;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  a;
   logic [5:0]  b;
   logic        done;
   logic [11:0] product;

   int compared;
   int mismatched;

   sign_mag_seq_mult dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  va;
      logic [5:0]  vb;
      logic [11:0] exp;
   } vec_t;

   function automatic logic [11:0] ref_prod(input int unsigned x, input int unsigned y);
      int unsigned ma, mb, m, s;
      ma = x % 32;
      mb = y % 32;
      m  = ma * mb;
      s  = ((x / 32) + (y / 32)) % 2;
      if (m == 0) s = 0;
      return 12'(s * 2048 + m);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Counts edges after the start edge until done, bounded, then checks the result.
   task automatic wait_result(input string name, input logic [11:0] exp);
      int n;
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("%s latency", name), n, 5);
      check($sformatf("%s done", name), int'(done), 1);
      check($sformatf("%s product", name), int'(product), int'(exp));
   endtask

   task automatic run_op(input string name, input logic [5:0] xa, input logic [5:0] xb,
                         input logic [11:0] exp);
      @(negedge clk);
      start = 1'b1; a = xa; b = xb;
      @(posedge clk); #1;
      start = 1'b0;
      a = 6'($urandom); b = 6'($urandom);
      check($sformatf("%s done_drop", name), int'(done), 0);
      wait_result(name, exp);
   endtask

   vec_t vecs[$];

   initial begin
      logic [11:0] held;
      compared   = 0;
      mismatched = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;

      vecs.push_back('{6'd63, 6'd63, 12'h3C1});
      vecs.push_back('{6'd4,  6'd5,  12'd20});
      vecs.push_back('{6'd17, 6'd3,  12'd51});
      vecs.push_back('{6'd16, 6'd22, 12'd352});
      vecs.push_back('{6'd1,  6'd1,  12'd1});
      vecs.push_back('{6'd1,  6'd22, 12'd22});
      vecs.push_back('{6'd22, 6'd1,  12'd22});
      vecs.push_back('{6'd0,  6'd0,  12'd0});
      vecs.push_back('{6'd0,  6'd16, 12'd0});
      vecs.push_back('{6'd16, 6'd0,  12'd0});
      vecs.push_back('{6'd32, 6'd32, 12'd0});
      vecs.push_back('{6'd32, 6'd5,  12'd0});
      vecs.push_back('{6'd33, 6'd5,  12'h805});
      vecs.push_back('{6'd63, 6'd31, 12'hBC1});

      repeat (3) @(posedge clk);
      #1;
      check("reset done", int'(done), 0);
      check("reset product", int'(product), 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle done", int'(done), 0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d(%0d*%0d)", i, vecs[i].va, vecs[i].vb),
                vecs[i].va, vecs[i].vb, vecs[i].exp);

      held = product;
      repeat (4) @(posedge clk);
      #1;
      check("hold done", int'(done), 1);
      check("hold product", int'(product), int'(held));

      // Restart while busy: only the second operand pair may show.
      @(negedge clk);
      start = 1'b1; a = 6'd63; b = 6'd63;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort busy", int'(done), 0);
      run_op("abort", 6'd33, 6'd5, 12'h805);

      // Start held several cycles: last loaded operands win.
      @(negedge clk);
      start = 1'b1; a = 6'd4; b = 6'd5;
      @(negedge clk);
      a = 6'd17; b = 6'd3;
      @(negedge clk);
      a = 6'd16; b = 6'd22;
      @(posedge clk); #1;
      start = 1'b0; a = 6'd0; b = 6'd0;
      wait_result("held_start", 12'd352);

      // Asynchronous clear while a result is being shown.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst done", int'(done), 0);
      check("async rst product", int'(product), 0);
      @(negedge clk) rst = 1'b0;

      // Reset mid-busy: no partial result afterwards, block sits idle.
      @(negedge clk);
      start = 1'b1; a = 6'd63; b = 6'd63;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst busy done", int'(done), 0);
      check("rst busy product", int'(product), 0);
      run_op("after_rst", 6'd33, 6'd63, ref_prod(33, 63));

      for (int k = 0; k < 150; k++) begin
         logic [5:0] ra, rb;
         ra = 6'($urandom);
         rb = 6'($urandom);
         if (k % 10 == 0) ra[4:0] = 5'd0;
         run_op($sformatf("rand%0d(%0d*%0d)", k, ra, rb), ra, rb, ref_prod(ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sign_mag_seq_mult.md
Name: sign_mag_seq_mult

Overview:
- Sequential shift-and-add multiplier for sign-magnitude operands.
- Each operand is WIDTH bits: the MSB is the sign (1 = negative) and the remaining WIDTH-1 bits are the unsigned magnitude.
- Returns a 2*WIDTH-bit sign-magnitude product a fixed number of cycles after a one-cycle start request.
- Standalone arithmetic leaf used by datapath/control logic that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 6, operand width including sign bit; magnitude width M = WIDTH-1; product width 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- start  input  1  load request, sampled on rising clk edge.
- a  input  WIDTH  multiplicand, sign-magnitude (a[WIDTH-1] = sign).
- b  input  WIDTH  multiplier, sign-magnitude.
- done  output  1  result valid (level).
- product  output  2*WIDTH  sign-magnitude result.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset values: done=0, product=0, state=IDLE, all internal registers 0.
- States: IDLE, BUSY, DONE.
- Load (any state, start=1 at edge L):
  - Capture mag_a = a[M-1:0] and mag_b = b[M-1:0].
  - Capture sign = a[WIDTH-1] XOR b[WIDTH-1].
  - Set accumulator = 0, iteration count = M.
  - Set done=0 and product=0; go to BUSY.
  - a and b are sampled only at edge L and may change afterwards.
- BUSY, one iteration per edge:
  - If the current multiplier LSB is 1, add the multiplicand (left-shifted by the iteration index, or equivalent right-shift accumulator form) into a 2M-bit accumulator.
  - Shift the multiplier; decrement count.
- Completion edge (M-th iteration edge, i.e. edge L+M; L+5 for WIDTH=6):
  - product[2*WIDTH-1] = sign, except forced to 0 when the magnitude is 0 (no negative zero).
  - product[2*WIDTH-2 : 2M] = 0 (bit 10 for WIDTH=6).
  - product[2M-1:0] = mag_a * mag_b.
  - done=1; go to DONE.
- DONE: product and done hold until the next start or rst.
- Latency: done and product valid M cycles after the start-sampling edge. The spec bound is ≤ 10 cycles.
- Restart: start asserted while BUSY aborts the current operation and loads the new operands (restart wins).
- start held high for several cycles: each high edge reloads; the result appears M edges after the last high edge.
- Holding start for exactly one cycle is the normal use.
- rst asserted mid-operation: immediate return to reset values; no partial result is exposed.
- No overflow is possible: the 2M-bit magnitude field is exact (max 31*31 = 961).

Decomposition:
- Shared package: WIDTH default and state enum (IDLE/BUSY/DONE).
- Optional sub-module: sign_mag_seq_mult_dp, holding the accumulator, shift registers and counter. The FSM stays in the top.
- A single module is also acceptable.

Test Plan:
- a=63 (−31), b=63 (−31), start for 1 cycle -> after ≤10 cycles done=1, product=961 (0x3C1, positive).
- a=4, b=5 -> 20. a=17, b=3 -> 51. a=16, b=22 -> 352. a=1, b=1 -> 1. a=1, b=22 and a=22, b=1 -> 22 both (commutativity).
- Zeros:
  - a=0, b=0 -> 0. a=0, b=16 and a=16, b=0 -> 0.
  - a=32 (−0), b=32 (−0) -> 0.
  - a=32 (−0), b=5 -> 0 (sign bit cleared, no −0).
- Negative result: a=33 (−1), b=5 -> product=0x805 (2053, sign bit set, magnitude 5). a=63, b=31 -> 0xBC1.
- Timing and handshake:
  - done stays low for exactly 5 edges after the start edge, then high; product holds while start=0.
  - A new start drops done the next edge.
- Abort and reset:
  - Assert start with new operands while BUSY -> result reflects only the new operands.
  - Pulse rst mid-BUSY -> done=0, product=0 immediately (asynchronous), and the block returns to IDLE.
